ram_input_arbiter: RTL and testbench

- Single-port arbiter in front of the 4096x32 data RAM. Shares the port between the CPU memory interface and a hardware input engine.
- The input engine keeps the controller mailbox at word addresses BASE_ADDR..BASE_ADDR+3 (up, down, right, left) equal to the synchronized button levels.
- It performs an init sweep after reset and alternates grants fairly when both sides contend.

---
 rtl/ram_map_pkg.sv | 34 +++
 rtl/ram_input_arbiter_if.sv | 31 +++
 rtl/btn_sync.sv | 33 +++
 rtl/ram_input_arbiter.sv | 154 +++++++++++++++
 tb/tb_ram_input_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_map_pkg.sv
// Shared definitions for the data-RAM input arbiter: mailbox slot map,
// FSM/owner encodings and the pending-slot priority helper.
package ram_map_pkg;

  localparam int unsigned DIR_UP    = 0;
  localparam int unsigned DIR_DOWN  = 1;
  localparam int unsigned DIR_RIGHT = 2;
  localparam int unsigned DIR_LEFT  = 3;
  localparam int unsigned NUM_DIRS  = 4;

  localparam int unsigned MBOX_BASE = 1;

  typedef enum logic [1:0] {
    RST_HOLD,
    INIT,
    RUN
  } state_e;

  typedef enum logic {
    OWN_CPU,
    OWN_HW
  } owner_e;

  // Lowest set index wins; returns 0 when nothing is set.
  function automatic logic [1:0] lowest_pending(input logic [NUM_DIRS-1:0] pend);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = int'(NUM_DIRS) - 1; i >= 0; i--) begin
      if (pend[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/ram_input_arbiter_if.sv
// CPU memory bus plus RAM port bundle; master is the CPU/RAM side,
// slave is the arbiter sitting between them.
interface ram_input_arbiter_if #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12
);

  logic                     cpu_req;
  logic                     cpu_wEn;
  logic [ADDRESS_WIDTH-1:0] cpu_addr;
  logic [DATA_WIDTH-1:0]    cpu_dataIn;
  logic                     cpu_gnt;
  logic                     cpu_rvalid;
  logic [DATA_WIDTH-1:0]    cpu_rdata;

  logic                     ram_wEn;
  logic [ADDRESS_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0]    ram_dataIn;
  logic [DATA_WIDTH-1:0]    ram_dataOut;

  modport master (
    output cpu_req, cpu_wEn, cpu_addr, cpu_dataIn, ram_dataOut,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, ram_wEn, ram_addr, ram_dataIn
  );

  modport slave (
    input  cpu_req, cpu_wEn, cpu_addr, cpu_dataIn, ram_dataOut,
    output cpu_gnt, cpu_rvalid, cpu_rdata, ram_wEn, ram_addr, ram_dataIn
  );

endinterface

// File: rtl/btn_sync.sv
// Multi-bit flop-chain synchronizer for slow asynchronous levels.
// Each bit is independent; no cross-bit coherence is implied.
module btn_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  // Fewer than two flops is not a synchronizer; clamp rather than misbehave.
  localparam int unsigned Stages = (STAGES < 2) ? 2 : STAGES;

  logic [WIDTH-1:0] r_chain [Stages];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int s = 0; s < int'(Stages); s++) begin
        r_chain[s] <= '0;
      end
    end else begin
      r_chain[0] <= i_async;
      for (int s = 1; s < int'(Stages); s++) begin
        r_chain[s] <= r_chain[s-1];
      end
    end
  end

  assign o_sync = r_chain[Stages-1];

endmodule

// File: rtl/ram_input_arbiter.sv
// Single-port data-RAM arbiter: shares the port between the CPU bus and a
// button engine that keeps four mailbox words equal to the button levels.
module ram_input_arbiter
  import ram_map_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned BASE_ADDR     = MBOX_BASE,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_btn_up,
  input  logic               i_btn_down,
  input  logic               i_btn_right,
  input  logic               i_btn_left,
  output logic               o_mbox_busy,
  ram_input_arbiter_if.slave bus
);

  localparam logic [ADDRESS_WIDTH-1:0] MboxBase = ADDRESS_WIDTH'(BASE_ADDR);

  state_e                   r_state, w_state_next;
  logic [1:0]               r_idx, w_idx_next;
  logic [NUM_DIRS-1:0]      r_shadow, w_shadow_next;
  logic [NUM_DIRS-1:0]      r_dirty, w_dirty_next;
  owner_e                   r_last_owner, w_last_owner_next;
  logic                     r_rvalid, w_rvalid_next;

  logic [NUM_DIRS-1:0]      w_btn;
  logic [NUM_DIRS-1:0]      w_sync;
  logic [NUM_DIRS-1:0]      w_pending;
  logic                     w_hw_req;
  logic [1:0]               w_slot;
  logic                     w_cpu_win;
  logic                     w_hw_win;
  logic [ADDRESS_WIDTH-1:0] w_mbox_off;
  logic                     w_mbox_hit;

  assign w_btn[DIR_UP]    = i_btn_up;
  assign w_btn[DIR_DOWN]  = i_btn_down;
  assign w_btn[DIR_RIGHT] = i_btn_right;
  assign w_btn[DIR_LEFT]  = i_btn_left;

  btn_sync #(
    .WIDTH  (NUM_DIRS),
    .STAGES (SYNC_STAGES)
  ) u_btn_sync (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_async   (w_btn),
    .o_sync    (w_sync)
  );

  // A slot needs a write if the button moved since the last HW write, or the
  // CPU scribbled on it; a pulse that reverts in between clears itself.
  assign w_pending = (w_sync ^ r_shadow) | r_dirty;
  assign w_hw_req  = |w_pending;
  assign w_slot    = lowest_pending(w_pending);

  assign w_mbox_off = bus.cpu_addr - MboxBase;
  assign w_mbox_hit = (w_mbox_off < ADDRESS_WIDTH'(NUM_DIRS));

  always_comb begin
    w_cpu_win = 1'b0;
    w_hw_win  = 1'b0;
    if (r_state == RUN) begin
      unique case ({bus.cpu_req, w_hw_req})
        2'b10: w_cpu_win = 1'b1;
        2'b01: w_hw_win  = 1'b1;
        2'b11: begin
          if (r_last_owner == OWN_HW) w_cpu_win = 1'b1;
          else                        w_hw_win  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_idx_next        = r_idx;
    w_shadow_next     = r_shadow;
    w_dirty_next      = r_dirty;
    w_last_owner_next = r_last_owner;
    w_rvalid_next     = 1'b0;
    bus.cpu_gnt       = 1'b0;
    bus.ram_wEn       = 1'b0;
    bus.ram_addr      = '0;
    bus.ram_dataIn    = '0;

    unique case (r_state)
      RST_HOLD: begin
        w_state_next = INIT;
        w_idx_next   = 2'd0;
      end

      INIT: begin
        bus.ram_wEn           = 1'b1;
        bus.ram_addr          = MboxBase + ADDRESS_WIDTH'(r_idx);
        bus.ram_dataIn        = DATA_WIDTH'(w_sync[r_idx]);
        w_shadow_next[r_idx]  = w_sync[r_idx];
        w_dirty_next[r_idx]   = 1'b0;
        w_idx_next            = r_idx + 2'd1;
        if (r_idx == 2'(NUM_DIRS - 1)) w_state_next = RUN;
      end

      RUN: begin
        if (w_cpu_win) begin
          bus.cpu_gnt       = 1'b1;
          bus.ram_wEn       = bus.cpu_wEn;
          bus.ram_addr      = bus.cpu_addr;
          bus.ram_dataIn    = bus.cpu_dataIn;
          w_rvalid_next     = ~bus.cpu_wEn;
          w_last_owner_next = OWN_CPU;
          // CPU may overwrite a mailbox word; HW puts it back on its next turn.
          if (bus.cpu_wEn && w_mbox_hit) w_dirty_next[w_mbox_off[1:0]] = 1'b1;
        end else if (w_hw_win) begin
          bus.ram_wEn           = 1'b1;
          bus.ram_addr          = MboxBase + ADDRESS_WIDTH'(w_slot);
          bus.ram_dataIn        = DATA_WIDTH'(w_sync[w_slot]);
          w_shadow_next[w_slot] = w_sync[w_slot];
          w_dirty_next[w_slot]  = 1'b0;
          w_last_owner_next     = OWN_HW;
        end
      end

      default: w_state_next = RST_HOLD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= RST_HOLD;
      r_idx        <= 2'd0;
      r_shadow     <= '0;
      r_dirty      <= '0;
      r_last_owner <= OWN_HW;
      r_rvalid     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      r_shadow     <= w_shadow_next;
      r_dirty      <= w_dirty_next;
      r_last_owner <= w_last_owner_next;
      r_rvalid     <= w_rvalid_next;
    end
  end

  assign bus.cpu_rvalid = r_rvalid;
  assign bus.cpu_rdata  = bus.ram_dataOut;
  assign o_mbox_busy    = (r_state != RUN) || w_hw_req;

endmodule

// File: tb/tb_ram_input_arbiter.sv
// Scoreboard bench: a RAM-content model predicts every cycle's port activity,
// a negedge monitor pops the predictions and compares.
module tb_ram_input_arbiter;
  import ram_map_pkg::*;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 12;
  localparam int unsigned BASE = 1;
  localparam int unsigned SS   = 2;

  typedef struct packed {
    logic          gnt;
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          busy;
    logic          rvalid;
  } port_t;

  typedef struct packed {
    port_t         p;
    logic [DW-1:0] rdata;
  } exp_t;

  typedef struct packed {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } op_t;

  typedef enum int {K_NONE, K_INIT, K_CPU, K_HW} kind_e;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] btn;
  logic       mbox_busy;
  logic       cpu_req;
  op_t        cur_op;

  int checks = 0;
  int errors = 0;

  ram_input_arbiter_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

  assign bus.cpu_req    = cpu_req;
  assign bus.cpu_wEn    = cur_op.wen;
  assign bus.cpu_addr   = cur_op.addr;
  assign bus.cpu_dataIn = cur_op.data;

  ram_input_arbiter #(
    .DATA_WIDTH    (DW),
    .ADDRESS_WIDTH (AW),
    .BASE_ADDR     (BASE),
    .SYNC_STAGES   (SS)
  ) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .i_btn_up    (btn[DIR_UP]),
    .i_btn_down  (btn[DIR_DOWN]),
    .i_btn_right (btn[DIR_RIGHT]),
    .i_btn_left  (btn[DIR_LEFT]),
    .o_mbox_busy (mbox_busy),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  // Behavioural RAM behind the arbiter: read-first, one-cycle read latency.
  logic [DW-1:0] ram_mem [1 << AW];
  always @(posedge clk) begin
    if (bus.ram_wEn) ram_mem[bus.ram_addr] <= bus.ram_dataIn;
    bus.ram_dataOut <= ram_mem[bus.ram_addr];
  end

  // Reference model state: what the RAM should contain and who touched the mailbox.
  logic [DW-1:0] m_mem [1 << AW];
  logic [3:0]    m_hist [SS];
  logic [3:0]    m_touched;
  owner_e        m_last;
  int            m_cyc;
  logic          m_prev_read;
  logic [DW-1:0] m_prev_rdata;
  logic          m_cpu_taken;
  kind_e         d_kind;
  exp_t          d_exp;
  int            d_slot;

  logic       rst_next;
  logic [3:0] btn_next;
  op_t        ops [$];
  exp_t       exp_q [$];

  function automatic op_t rand_op();
    op_t o;
    o.wen  = 1'($urandom_range(0, 1));
    o.addr = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
    o.data = $urandom;
    return o;
  endfunction

  task automatic predict();
    exp_t       e;
    logic [3:0] sync;
    logic [3:0] pend;
    int         slot;
    e = '0;
    if (!reset_n) begin
      for (int s = 0; s < int'(SS); s++) m_hist[s] = '0;
      m_touched   = '0;
      m_last      = OWN_HW;
      m_cyc       = 0;
      m_prev_read = 1'b0;
      d_kind      = K_NONE;
      e.p.busy    = 1'b1;
    end else begin
      sync        = m_hist[SS-1];
      e.p.rvalid  = m_prev_read;
      e.rdata     = m_prev_rdata;
      m_prev_read = 1'b0;
      d_kind      = K_NONE;
      if (m_cyc == 0) begin
        e.p.busy = 1'b1;
      end else if (m_cyc <= int'(NUM_DIRS)) begin
        slot     = m_cyc - 1;
        d_kind   = K_INIT;
        d_slot   = slot;
        e.p.wen  = 1'b1;
        e.p.addr = AW'(int'(BASE) + slot);
        e.p.data = DW'(sync[slot]);
        e.p.busy = 1'b1;
      end else begin
        slot = 0;
        for (int i = 3; i >= 0; i--) begin
          pend[i] = m_touched[i] || (m_mem[int'(BASE) + i] != DW'(sync[i]));
          if (pend[i]) slot = i;
        end
        if (cpu_req && pend != 0) d_kind = (m_last == OWN_CPU) ? K_HW : K_CPU;
        else if (cpu_req)         d_kind = K_CPU;
        else if (pend != 0)       d_kind = K_HW;
        e.p.busy = (pend != 0);
        if (d_kind == K_CPU) begin
          e.p.gnt  = 1'b1;
          e.p.wen  = cur_op.wen;
          e.p.addr = cur_op.addr;
          e.p.data = cur_op.data;
          if (!cur_op.wen) begin
            m_prev_read  = 1'b1;
            m_prev_rdata = m_mem[cur_op.addr];
          end
        end else if (d_kind == K_HW) begin
          d_slot   = slot;
          e.p.wen  = 1'b1;
          e.p.addr = AW'(int'(BASE) + slot);
          e.p.data = DW'(sync[slot]);
        end
      end
    end
    d_exp = e;
    exp_q.push_back(e);
  endtask

  task automatic commit();
    int off;
    if (reset_n) begin
      if (d_exp.p.wen) m_mem[d_exp.p.addr] = d_exp.p.data;
      case (d_kind)
        K_INIT: m_touched[d_slot] = 1'b0;
        K_HW: begin
          m_touched[d_slot] = 1'b0;
          m_last            = OWN_HW;
        end
        K_CPU: begin
          m_last = OWN_CPU;
          off    = int'(cur_op.addr) - int'(BASE);
          if (cur_op.wen && off >= 0 && off < 4) m_touched[off] = 1'b1;
        end
        default: ;
      endcase
      for (int s = int'(SS) - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
      m_hist[0] = btn;
      if (m_cyc < 1000) m_cyc++;
    end
    m_cpu_taken = reset_n && (d_kind == K_CPU);
  endtask

  task automatic tick();
    @(posedge clk);
    commit();
    #1;
    reset_n = rst_next;
    btn     = btn_next;
    // CPU keeps its request stable until it has been granted.
    if (!cpu_req || m_cpu_taken) begin
      if (ops.size() > 0) begin
        cur_op  = ops.pop_front();
        cpu_req = 1'b1;
      end else begin
        cpu_req = 1'b0;
      end
    end
    predict();
  endtask

  always @(negedge clk) begin
    exp_t  e;
    port_t a;
    if (exp_q.size() != 0) begin
      e        = exp_q.pop_front();
      a.gnt    = bus.cpu_gnt;
      a.wen    = bus.ram_wEn;
      a.addr   = bus.ram_addr;
      a.data   = bus.ram_dataIn;
      a.busy   = mbox_busy;
      a.rvalid = bus.cpu_rvalid;
      checks++;
      if (a !== e.p) begin
        errors++;
        $display("FAIL port t=%0t got gnt=%b wen=%b addr=%h data=%h busy=%b rvalid=%b, want gnt=%b wen=%b addr=%h data=%h busy=%b rvalid=%b",
                 $time, a.gnt, a.wen, a.addr, a.data, a.busy, a.rvalid,
                 e.p.gnt, e.p.wen, e.p.addr, e.p.data, e.p.busy, e.p.rvalid);
      end
      if (e.p.rvalid && bus.cpu_rvalid) begin
        checks++;
        if (bus.cpu_rdata !== e.rdata) begin
          errors++;
          $display("FAIL rdata t=%0t got %h want %h", $time, bus.cpu_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    int   guard;
    op_t  o;
    reset_n   = 1'b0;
    rst_next  = 1'b0;
    btn       = '0;
    btn_next  = '0;
    cpu_req   = 1'b0;
    cur_op    = '0;
    m_touched = '0;
    m_last    = OWN_HW;
    m_cyc     = 0;
    m_prev_read  = 1'b0;
    m_prev_rdata = '0;
    d_kind    = K_NONE;
    d_exp     = '0;
    d_slot    = 0;
    for (int s = 0; s < int'(SS); s++) m_hist[s] = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      ram_mem[i] = (i * 32'h9E37_79B1) ^ 32'h5A5A_0000;
      m_mem[i]   = ram_mem[i];
    end
    ram_mem[12'h100] = 32'h0000_BEEF;
    m_mem[12'h100]   = 32'h0000_BEEF;

    // Reset and init sweep with a CPU read already waiting.
    o = '{wen: 1'b0, addr: 12'h100, data: 32'h0};
    ops.push_back(o);
    repeat (3) tick();
    rst_next = 1'b1;
    repeat (12) tick();

    btn_next[DIR_UP] = 1'b1;
    repeat (6) tick();

    // Continuous CPU traffic against two simultaneous button edges.
    for (int i = 0; i < 12; i++) begin
      o = '{wen: 1'(i), addr: AW'(32'h200 + i), data: $urandom};
      ops.push_back(o);
    end
    btn_next[DIR_RIGHT] = 1'b1;
    btn_next[DIR_LEFT]  = 1'b1;
    repeat (14) tick();

    btn_next[DIR_RIGHT] = 1'b0;
    btn_next[DIR_LEFT]  = 1'b0;
    repeat (6) tick();
    o = '{wen: 1'b1, addr: AW'(BASE + DIR_RIGHT), data: 32'hDEAD_BEEF};
    ops.push_back(o);
    repeat (6) tick();
    o = '{wen: 1'b0, addr: AW'(BASE + DIR_RIGHT), data: 32'h0};
    ops.push_back(o);
    repeat (4) tick();

    for (int c = 0; c < 800; c++) begin
      int k;
      if (ops.size() < 2 && $urandom_range(0, 2) != 0) ops.push_back(rand_op());
      if ($urandom_range(0, 9) == 0) begin
        k = $urandom_range(0, 3);
        btn_next[k] = ~btn_next[k];
      end
      tick();
    end

    // Reset in the middle of the init sweep: the port must go quiet at once.
    rst_next = 1'b0;
    repeat (2) tick();
    rst_next = 1'b1;
    guard = 0;
    while (m_cyc != 3 && guard < 20) begin
      tick();
      guard++;
    end
    checks++;
    if (m_cyc != 3) begin
      errors++;
      $display("FAIL init_reach got cyc=%0d want 3", m_cyc);
    end
    @(negedge clk);
    #1;
    reset_n  = 1'b0;
    rst_next = 1'b0;
    #1;
    checks++;
    if (bus.ram_wEn !== 1'b0 || bus.cpu_gnt !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got wEn=%b gnt=%b want 0 0", bus.ram_wEn, bus.cpu_gnt);
    end
    repeat (2) tick();
    rst_next = 1'b1;
    for (int c = 0; c < 60; c++) begin
      if (ops.size() < 2 && $urandom_range(0, 1) != 0) ops.push_back(rand_op());
      tick();
    end
    repeat (3) tick();
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d entries want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
